wr_en_decoder_2p: RTL and testbench

WR_EN_DECODER_2P -- requirements
Module: wr_en_decoder_2p

---
 rtl/wr_en_decoder_2p_if.sv | 23 ++
 rtl/wr_en_decoder_2p.sv | 114 +++++++++++
 tb/tb_wr_en_decoder_2p.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wr_en_decoder_2p_if.sv
// rtl/wr_en_decoder_2p_if.sv - two write-request ports (valid/addr/ready) bundled for the write-enable decoder
interface wr_en_decoder_2p_if #(
    parameter int ADDR_W = 5
);
    logic              wr0_valid;
    logic [ADDR_W-1:0] wr0_addr;
    logic              wr0_ready;
    logic              wr1_valid;
    logic [ADDR_W-1:0] wr1_addr;
    logic              wr1_ready;

    // Requester side: drives requests, observes accepts.
    modport master (
        output wr0_valid, wr0_addr, wr1_valid, wr1_addr,
        input  wr0_ready, wr1_ready
    );

    // Decoder side: observes requests, drives accepts.
    modport slave (
        input  wr0_valid, wr0_addr, wr1_valid, wr1_addr,
        output wr0_ready, wr1_ready
    );
endinterface

// File: rtl/wr_en_decoder_2p.sv
// rtl/wr_en_decoder_2p.sv - two-port one-hot register write-enable decoder with same-address replay; option macro ZERO_REG_SUPPRESS_EN
module wr_en_decoder_2p #(
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    wr_en_decoder_2p_if.slave      wr,
    output logic [2**ADDR_W-1:0]   we0,
    output logic [2**ADDR_W-1:0]   we1,
    output logic                   pending,
    output logic [15:0]            conflict_cnt
);
    localparam int NREG = 2**ADDR_W;

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] hold_addr;
    logic [15:0]       cnt_q;
    logic [NREG-1:0]   we0_q;
    logic [NREG-1:0]   we1_q;
    logic              pending_q;

    logic              rdy;
    logic              acc0;
    logic              acc1;
    logic              zero0;
    logic              zero1;
    logic              conflict;

    // Register index to one-hot enable vector.
    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Both ports share one accept: only in IDLE, never while flushing or in reset.
    assign rdy          = reset_n && (state == IDLE) && !flush;
    assign wr.wr0_ready = rdy;
    assign wr.wr1_ready = rdy;

    assign acc0 = wr.wr0_valid && rdy;
    assign acc1 = wr.wr1_valid && rdy;

`ifdef ZERO_REG_SUPPRESS_EN
    // The top register is hard-wired zero: writes are accepted and silently dropped.
    assign zero0 = (wr.wr0_addr == {ADDR_W{1'b1}});
    assign zero1 = (wr.wr1_addr == {ADDR_W{1'b1}});
`else
    assign zero0 = 1'b0;
    assign zero1 = 1'b0;
`endif

    // Same-address collision; a dropped zero-register write can never collide.
    assign conflict = acc0 && acc1 && (wr.wr0_addr == wr.wr1_addr) && !zero0;

    // Decode state, replay hold path and saturating conflict counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold_addr <= '0;
            cnt_q     <= '0;
            we0_q     <= '0;
            we1_q     <= '0;
            pending_q <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            hold_addr <= '0;
            we0_q     <= '0;
            we1_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    we0_q <= (acc0 && !zero0) ? onehot(wr.wr0_addr) : '0;
                    we1_q <= (acc1 && !zero1 && !conflict) ? onehot(wr.wr1_addr) : '0;
                    if (conflict) begin
                        hold_addr <= wr.wr1_addr;
                        state     <= REPLAY;
                        pending_q <= 1'b1;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end else begin
                        pending_q <= 1'b0;
                    end
                end
                REPLAY: begin
                    we0_q     <= '0;
                    we1_q     <= onehot(hold_addr);
                    pending_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    we0_q     <= '0;
                    we1_q     <= '0;
                    pending_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign we0          = we0_q;
    assign we1          = we1_q;
    assign pending      = pending_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_wr_en_decoder_2p.sv
// tb/tb_wr_en_decoder_2p.sv - self-checking bench for wr_en_decoder_2p
`timescale 1ns/1ps
module tb_wr_en_decoder_2p;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
`ifdef ZERO_REG_SUPPRESS_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif
    localparam logic [31:0] Z31 = ZS ? 32'h0 : 32'h8000_0000;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic [NREG-1:0]  we0;
    logic [NREG-1:0]  we1;
    logic             pending;
    logic [15:0]      conflict_cnt;

    wr_en_decoder_2p_if #(.ADDR_W(ADDR_W)) wif ();

    wr_en_decoder_2p #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .wr           (wif),
        .we0          (we0),
        .we1          (we1),
        .pending      (pending),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          v0;
        int          a0;
        bit          v1;
        int          a1;
        bit          fl;
        bit          e_rdy;
        logic [31:0] e_we0;
        logic [31:0] e_we1;
        bit          e_pend;
    } vec_t;

    vec_t tbl[10];

    // Reference model: a deferred port-1 write waits one cycle, everything else is immediate.
    bit          m_replay;
    int          m_hold;
    int          m_cnt;
    logic [31:0] m_we0;
    logic [31:0] m_we1;
    bit          m_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dec(input int a);
        if (ZS && a == NREG - 1) return 32'h0;
        return 32'(1) << a;
    endfunction

    function automatic bit m_ready(input bit fl);
        return !m_replay && !fl;
    endfunction

    task automatic model_reset();
        m_replay = 0; m_hold = 0; m_cnt = 0;
        m_we0 = 0; m_we1 = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit v0, input int a0, input bit v1, input int a1, input bit fl);
        bit acc0, acc1, same;
        acc0 = v0 && m_ready(fl);
        acc1 = v1 && m_ready(fl);
        if (fl) begin
            m_we0 = 0; m_we1 = 0; m_pend = 0; m_replay = 0;
        end else if (m_replay) begin
            m_we0 = 0; m_we1 = dec(m_hold); m_pend = 0; m_replay = 0;
        end else begin
            same  = acc0 && acc1 && (a0 == a1) && (dec(a0) != 0);
            m_we0 = acc0 ? dec(a0) : 32'h0;
            m_we1 = (acc1 && !same) ? dec(a1) : 32'h0;
            m_pend = same;
            if (same) begin
                m_replay = 1;
                m_hold   = a1;
                m_cnt    = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end
        end
    endtask

    // Drive one cycle of stimulus; returns the readies seen before the edge, ends at the next negedge.
    task automatic apply(input bit v0, input int a0, input bit v1, input int a1, input bit fl,
                         output logic r0, output logic r1);
        wif.wr0_valid = v0; wif.wr0_addr = a0[ADDR_W-1:0];
        wif.wr1_valid = v1; wif.wr1_addr = a1[ADDR_W-1:0];
        flush = fl;
        #1;
        r0 = wif.wr0_ready;
        r1 = wif.wr1_ready;
        model_step(v0, a0, v1, a1, fl);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cycle(input string nm, input bit v0, input int a0, input bit v1, input int a1, input bit fl);
        logic r0, r1;
        bit   er;
        er = m_ready(fl);
        apply(v0, a0, v1, a1, fl, r0, r1);
        chk({nm, "_rdy0"}, 32'(r0), 32'(er));
        chk({nm, "_rdy1"}, 32'(r1), 32'(er));
        chk({nm, "_we0"}, we0, m_we0);
        chk({nm, "_we1"}, we1, m_we1);
        chk({nm, "_pend"}, 32'(pending), 32'(m_pend));
        chk({nm, "_cnt"}, 32'(conflict_cnt), 32'(m_cnt));
        chk({nm, "_onehot"}, 32'(($countones(we0) <= 1) && ($countones(we1) <= 1)), 32'd1);
    endtask

    initial begin
        logic r0, r1;
        int   a0, a1;

        tbl[0] = '{1, 4,  0, 0,  0, 1, 32'h0000_0010, 32'h0,         0};
        tbl[1] = '{1, 3,  1, 7,  0, 1, 32'h0000_0008, 32'h0000_0080, 0};
        tbl[2] = '{0, 0,  1, 31, 0, 1, 32'h0,         Z31,           0};
        tbl[3] = '{1, 8,  1, 8,  0, 1, 32'h0000_0100, 32'h0,         1};
        tbl[4] = '{1, 1,  1, 2,  0, 0, 32'h0,         32'h0000_0100, 0};
        tbl[5] = '{0, 0,  0, 0,  0, 1, 32'h0,         32'h0,         0};
        tbl[6] = '{1, 5,  1, 5,  0, 1, 32'h0000_0020, 32'h0,         1};
        tbl[7] = '{1, 9,  1, 9,  1, 0, 32'h0,         32'h0,         0};
        tbl[8] = '{0, 0,  0, 0,  0, 1, 32'h0,         32'h0,         0};
        tbl[9] = '{1, 12, 1, 12, 1, 0, 32'h0,         32'h0,         0};

        wif.wr0_valid = 0; wif.wr0_addr = '0;
        wif.wr1_valid = 0; wif.wr1_addr = '0;
        model_reset();

        // Reset state.
        #1;
        chk("rst_we0", we0, 32'h0);
        chk("rst_we1", we1, 32'h0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        chk("rst_rdy0", 32'(wif.wr0_ready), 32'd0);
        chk("rst_rdy1", 32'(wif.wr1_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_rdy0", 32'(wif.wr0_ready), 32'd1);

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1, tbl[i].fl, r0, r1);
            chk($sformatf("tbl%0d_rdy", i), 32'(r0 & r1), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_we0", i), we0, tbl[i].e_we0);
            chk($sformatf("tbl%0d_we1", i), we1, tbl[i].e_we1);
            chk($sformatf("tbl%0d_pend", i), 32'(pending), 32'(tbl[i].e_pend));
        end
        chk("tbl_cnt", 32'(conflict_cnt), 32'd2);

        // Address sweep, distinct addresses on the two ports.
        for (int a = 0; a < NREG; a++) begin
            drive_cycle($sformatf("sweep%0d", a), 1, a, 1, (a + 1) % NREG, 0);
        end
        chk("sweep_cnt", 32'(conflict_cnt), 32'd2);

        // Top-address collision: a conflict normally, ignored under zero-register suppression.
        drive_cycle("z31_a", 1, 31, 1, 31, 0);
        drive_cycle("z31_b", 0, 0, 0, 0, 0);

        // Randomized traffic with frequent address collisions and occasional flush.
        for (int n = 0; n < 400; n++) begin
            a0 = $urandom_range(0, NREG - 1);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, NREG - 1);
            drive_cycle("rnd", 1'($urandom_range(0, 1)), a0, 1'($urandom_range(0, 1)), a1,
                        $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset in the middle of a replay.
        drive_cycle("pre_rst", 1, 8, 1, 8, 0);
        chk("pre_rst_pend", 32'(pending), 32'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_we0", we0, 32'h0);
        chk("mid_rst_we1", we1, 32'h0);
        chk("mid_rst_pend", 32'(pending), 32'd0);
        chk("mid_rst_cnt", 32'(conflict_cnt), 32'd0);
        chk("mid_rst_rdy", 32'(wif.wr0_ready | wif.wr1_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_rdy", 32'(wif.wr0_ready & wif.wr1_ready), 32'd1);
        drive_cycle("post_rst", 0, 0, 0, 0, 0);

        // Counter saturation from a preset value near the top.
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 65534;
        drive_cycle("sat1", 1, 6, 1, 6, 0);
        drive_cycle("sat1r", 0, 0, 0, 0, 0);
        drive_cycle("sat2", 1, 7, 1, 7, 0);
        drive_cycle("sat2r", 0, 0, 0, 0, 0);
        drive_cycle("sat3", 1, 2, 1, 2, 0);
        chk("sat_cnt", 32'(conflict_cnt), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
